fetch_stage: RTL and testbench

- First pipeline stage. Owns the program counter and issues single-outstanding word requests to instruction memory.
- Feeds decode through the prev_done/stall_prev handshake: this block drives done_next and receives next_stall.
- Consumes decode's redirect (control_flow_affected, jump_target, jump_target_valid) to squash wrong-path fetches and reload the PC.

---
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one outstanding word request at a time,
// and holds a single-entry output buffer that feeds decode.
module fetch_stage #(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    INSTRUCTION_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         next_stall,
    output logic                         done_next,
    output logic [ADDR_WIDTH-1:0]        program_count,
    output logic                         program_count_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data,
    output logic                         instruction_data_valid,
    input  logic                         control_flow_affected,
    input  logic [ADDR_WIDTH-1:0]        jump_target,
    input  logic                         jump_target_valid,
    output logic                         imem_req,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    input  logic                         imem_ready,
    input  logic                         imem_rsp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
    input  logic                         imem_rsp_error
);

    // state  | meaning
    // S_REQ  | idle, may issue a request (or consume a misaligned PC locally)
    // S_WAIT | request accepted, response still owed to this fetch
    // S_DROP | redirected while waiting, the owed response is discarded
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t                         state, state_next;
    logic [ADDR_WIDTH-1:0]          fetch_pc, fetch_pc_next;
    logic [ADDR_WIDTH-1:0]          buf_pc, buf_pc_next;
    logic [INSTRUCTION_WIDTH-1:0]   buf_data, buf_data_next;
    logic                           buf_ok, buf_ok_next;
    logic                           has_output, has_output_next;
    logic                           redirect, transfer, buf_free, pc_aligned, handshake;

    assign redirect   = control_flow_affected && jump_target_valid;
    assign done_next  = has_output && !redirect;
    assign transfer   = done_next && !next_stall;
    assign buf_free   = !has_output || transfer;
    assign pc_aligned = (fetch_pc[1:0] == 2'b00);

    assign imem_req  = (state == S_REQ) && !rst && buf_free && !redirect && pc_aligned;
    assign imem_addr = fetch_pc;
    assign handshake = imem_req && imem_ready;

    assign program_count          = buf_pc;
    assign program_count_valid    = has_output;
    assign instruction_data       = buf_data;
    assign instruction_data_valid = has_output && buf_ok;

    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        has_output_next = has_output && !transfer;
        buf_pc_next     = buf_pc;
        buf_data_next   = buf_data;
        buf_ok_next     = buf_ok;
        case (state)
            S_REQ: begin
                if (handshake) begin
                    state_next = S_WAIT;
                end else if (!pc_aligned && buf_free && !redirect) begin
                    has_output_next = 1'b1;
                    buf_pc_next     = fetch_pc;
                    buf_data_next   = '0;
                    buf_ok_next     = 1'b0;
                    fetch_pc_next   = fetch_pc + ADDR_WIDTH'(4);
                end
            end
            S_WAIT: begin
                // A request is only issued with the buffer free, so a response never overwrites it.
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                    if (!redirect) begin
                        has_output_next = 1'b1;
                        buf_pc_next     = fetch_pc;
                        buf_data_next   = imem_rsp_data;
                        buf_ok_next     = !imem_rsp_error;
                        fetch_pc_next   = fetch_pc + ADDR_WIDTH'(4);
                    end
                end else if (redirect) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
        if (redirect) begin
            fetch_pc_next   = jump_target;
            has_output_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            has_output <= 1'b0;
            buf_pc     <= '0;
            buf_data   <= '0;
            buf_ok     <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            has_output <= has_output_next;
            buf_pc     <= buf_pc_next;
            buf_data   <= buf_data_next;
            buf_ok     <= buf_ok_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level reference model plus a bench-side memory,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        next_stall;
    logic        done_next;
    logic [31:0] program_count;
    logic        program_count_valid;
    logic [31:0] instruction_data;
    logic        instruction_data_valid;
    logic        control_flow_affected;
    logic [31:0] jump_target;
    logic        jump_target_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_error;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .next_stall(next_stall), .done_next(done_next),
        .program_count(program_count), .program_count_valid(program_count_valid),
        .instruction_data(instruction_data), .instruction_data_valid(instruction_data_valid),
        .control_flow_affected(control_flow_affected), .jump_target(jump_target),
        .jump_target_valid(jump_target_valid), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_error(imem_rsp_error)
    );

    int checks = 0;
    int errors = 0;

    // stimulus knobs
    bit          s_stall, s_cfa, s_jtv, s_ready, random_mode;
    logic [31:0] s_jt, err_addr;

    // bench memory: one outstanding request, response after mem_cnt+1 cycles
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    // reference model: PC, buffered instruction, and the one request in flight
    logic [31:0] m_pc, m_buf_pc, m_buf_data;
    bit          m_buf_v, m_buf_ok, m_pending, m_squashed;

    logic [31:0] acc_q[$];
    logic [31:0] del_pc_q[$];
    logic [31:0] del_data_q[$];
    bit          del_ok_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r);
        bit          rsp_v, rsp_e, redir, e_done, e_xfer, e_free, e_req, acc;
        logic [31:0] rsp_d;
        @(negedge clk);
        rst                   = r;
        next_stall            = s_stall;
        control_flow_affected = s_cfa;
        jump_target_valid     = s_jtv;
        jump_target           = s_jt;
        imem_ready            = s_ready;
        if (r) begin
            mem_busy = 0; m_pc = 32'h0; m_buf_v = 0; m_pending = 0; m_squashed = 0;
        end
        rsp_v = mem_busy && (mem_cnt == 0) && !r;
        if (rsp_v) begin
            rsp_d = random_mode ? $urandom : word_of(mem_addr);
            rsp_e = random_mode ? ($urandom_range(0, 7) == 0) : (mem_addr == err_addr);
        end else begin
            rsp_d = $urandom;
            rsp_e = 1'($urandom_range(0, 1));
        end
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_d;
        imem_rsp_error = rsp_e;
        #1;
        redir  = s_cfa && s_jtv;
        e_done = m_buf_v && !redir;
        e_xfer = e_done && !s_stall;
        e_free = !m_buf_v || e_xfer;
        e_req  = !r && !m_pending && e_free && !redir && (m_pc[1:0] == 2'b00);
        chk("done_next", done_next, e_done);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("program_count_valid", program_count_valid, m_buf_v);
        chk("instruction_data_valid", instruction_data_valid, m_buf_v && m_buf_ok);
        if (m_buf_v) begin
            chk("program_count", program_count, m_buf_pc);
            chk("instruction_data", instruction_data, m_buf_data);
        end
        if (done_next && !next_stall) begin
            del_pc_q.push_back(program_count);
            del_data_q.push_back(instruction_data);
            del_ok_q.push_back(instruction_data_valid);
        end
        if (imem_req && imem_ready) acc_q.push_back(imem_addr);
        if (!r) begin
            acc = e_req && s_ready;
            if (redir) begin
                m_pc    = s_jt;
                m_buf_v = 0;
                if (m_pending) begin
                    if (rsp_v) m_pending = 0;
                    else       m_squashed = 1;
                end
            end else begin
                if (e_xfer) m_buf_v = 0;
                if (m_pending) begin
                    if (rsp_v) begin
                        if (!m_squashed) begin
                            m_buf_v = 1; m_buf_pc = m_pc; m_buf_data = rsp_d; m_buf_ok = !rsp_e;
                            m_pc = m_pc + 32'd4;
                        end
                        m_pending  = 0;
                        m_squashed = 0;
                    end
                end else if (acc) begin
                    m_pending  = 1;
                    m_squashed = 0;
                end else if (m_pc[1:0] != 2'b00 && e_free) begin
                    m_buf_v = 1; m_buf_pc = m_pc; m_buf_data = 32'h0; m_buf_ok = 0;
                    m_pc = m_pc + 32'd4;
                end
            end
            if (rsp_v)         mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (imem_req && imem_ready) begin
                mem_busy = 1;
                mem_addr = imem_addr;
                mem_cnt  = random_mode ? $urandom_range(0, 2) : 0;
            end
        end
    endtask

    initial begin
        int n_acc;
        logic [31:0] tmp;
        int redir_left;
        rst = 1'b1; next_stall = 0; control_flow_affected = 0; jump_target_valid = 0;
        jump_target = '0; imem_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; imem_rsp_error = 0;
        s_stall = 0; s_cfa = 0; s_jtv = 0; s_jt = '0; s_ready = 1; random_mode = 0;
        err_addr = 32'hC; redir_left = 0;

        step(1);
        step(1);
        chk("reset_imem_req", imem_req, 1'b0);
        chk("reset_done_next", done_next, 1'b0);

        // straight-line fetch from 0 with 1-cycle memory; 0xC returns a bus error
        repeat (14) step(0);
        chk("acc_count", 32'(acc_q.size() >= 3), 32'd1);
        if (acc_q.size() >= 3) begin
            chk("acc0", acc_q[0], 32'h0);
            chk("acc1", acc_q[1], 32'h4);
            chk("acc2", acc_q[2], 32'h8);
        end
        chk("del_count", 32'(del_pc_q.size() >= 5), 32'd1);
        if (del_pc_q.size() >= 5) begin
            chk("del0_pc", del_pc_q[0], 32'h0);
            chk("del1_pc", del_pc_q[1], 32'h4);
            chk("del2_pc", del_pc_q[2], 32'h8);
            chk("del2_data", del_data_q[2], 32'hA5CB_0008);
            chk("del2_ok", del_ok_q[2], 1'b1);
            chk("del3_pc", del_pc_q[3], 32'hC);
            chk("del3_err_ok", del_ok_q[3], 1'b0);
            chk("del4_pc", del_pc_q[4], 32'h10);
            chk("del4_ok", del_ok_q[4], 1'b1);
        end

        // decode stalls with a full buffer: nothing new may be requested
        n_acc = acc_q.size();
        s_stall = 1;
        repeat (5) step(0);
        chk("stall_done_held", done_next, 1'b1);
        chk("stall_no_new_req", acc_q.size(), n_acc);
        s_stall = 0;

        // one-cycle redirect to a misaligned target
        acc_q.delete(); del_pc_q.delete(); del_data_q.delete(); del_ok_q.delete();
        s_cfa = 1; s_jtv = 1; s_jt = 32'h102;
        step(0);
        s_cfa = 0; s_jtv = 0;
        repeat (10) step(0);
        chk("mis_del_count", 32'(del_pc_q.size() >= 2), 32'd1);
        if (del_pc_q.size() >= 2) begin
            chk("mis_del0_pc", del_pc_q[0], 32'h102);
            chk("mis_del0_ok", del_ok_q[0], 1'b0);
            chk("mis_del1_pc", del_pc_q[1], 32'h106);
            chk("mis_del1_ok", del_ok_q[1], 1'b0);
        end
        foreach (acc_q[i]) chk("mis_no_mem_access", 32'(acc_q[i][1:0]), 32'd0);

        // randomized traffic, including held redirects, PC wrap and a mid-run reset
        random_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            s_stall = ($urandom_range(0, 9) < 3);
            s_ready = ($urandom_range(0, 9) < 7);
            if (redir_left > 0) begin
                redir_left--;
            end else if ($urandom_range(0, 19) == 0) begin
                redir_left = $urandom_range(0, 2);
                tmp = $urandom;
                case ($urandom_range(0, 7))
                    0:       s_jt = (tmp & 32'h0000_0FFC) | 32'h2;
                    1:       s_jt = 32'hFFFF_FFF4;
                    default: s_jt = tmp & 32'h0000_0FFC;
                endcase
                s_cfa = 1; s_jtv = 1;
            end else begin
                s_cfa = ($urandom_range(0, 9) == 0);
                s_jtv = !s_cfa && ($urandom_range(0, 9) == 0);
                s_jt  = $urandom;
            end
            step(i == 1500 || i == 1501);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
